// File: rtl/uart_mitm_pkg.sv
// Shared definitions for the UART MITM engine.
//   mode_e       : per-direction mode codes (6 and 7 behave as BLOCK)
//   send_state_e : send FSM states
//   ROT_*        : ROT13 letter ranges on the zero-extended byte value
package uart_mitm_pkg;

  typedef enum logic [2:0] {
    MODE_FORWARD    = 3'd0,
    MODE_BLOCK      = 3'd1,
    MODE_SUB        = 3'd2,
    MODE_ROT13      = 3'd3,
    MODE_XOR        = 3'd4,
    MODE_MATCH_REPL = 3'd5
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } send_state_e;

  localparam int unsigned ROT_UC_LO_FIRST = 65;   // 'A'
  localparam int unsigned ROT_UC_LO_LAST  = 77;   // 'M'
  localparam int unsigned ROT_UC_HI_FIRST = 78;   // 'N'
  localparam int unsigned ROT_UC_HI_LAST  = 90;   // 'Z'
  localparam int unsigned ROT_LC_LO_FIRST = 97;   // 'a'
  localparam int unsigned ROT_LC_LO_LAST  = 109;  // 'm'
  localparam int unsigned ROT_LC_HI_FIRST = 110;  // 'n'
  localparam int unsigned ROT_LC_HI_LAST  = 122;  // 'z'
  localparam int unsigned ROT_SHIFT       = 13;

endpackage

// File: rtl/mitm_direction_channel.sv
// One MITM direction: byte transform, FIFO, send FSM, injected-byte counter
// and sticky overflow flag.
//   mode_in                     : requested mode, adopted only while idle
//   sub_char/xor_key/match_char/replace_char : operands, used at enqueue
//   clear_status                : clears ovf and cnt (beats increment)
//   recv_new_data/recv_data     : received-byte strobe and value
//   send_ready/send_done        : fake sender status
//   select/send_start/keep_alive/send_data : fake sender controls
//   ovf/cnt                     : sticky overflow flag, injected-byte count
module mitm_direction_channel
  import uart_mitm_pkg::*;
#(
  parameter int unsigned NUM_DATA_BITS = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned MODE_W        = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MODE_W-1:0]        mode_in,
  input  logic [NUM_DATA_BITS-1:0] sub_char,
  input  logic [NUM_DATA_BITS-1:0] xor_key,
  input  logic [NUM_DATA_BITS-1:0] match_char,
  input  logic [NUM_DATA_BITS-1:0] replace_char,
  input  logic                     clear_status,
  input  logic                     recv_new_data,
  input  logic [NUM_DATA_BITS-1:0] recv_data,
  input  logic                     send_ready,
  input  logic                     send_done,
  output logic                     select,
  output logic                     send_start,
  output logic                     keep_alive,
  output logic [NUM_DATA_BITS-1:0] send_data,
  output logic                     ovf,
  output logic [CNT_W-1:0]         cnt
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ZW = (NUM_DATA_BITS > 32) ? NUM_DATA_BITS : 32;
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  logic [NUM_DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  send_state_e              state_q, state_d;
  logic [MODE_W-1:0]        mode_q, mode_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]              count_q, count_d;
  logic                     select_q, select_d;
  logic                     send_start_q, send_start_d;
  logic                     keep_alive_q, keep_alive_d;
  logic [NUM_DATA_BITS-1:0] send_data_q, send_data_d;
  logic                     ovf_q, ovf_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     enq, push, pop, full, idle;
  logic [NUM_DATA_BITS-1:0] xform;
  logic [ZW-1:0]            rot_z;

  // Transform uses the active mode, so a queued byte is always the product
  // of a single mode even if mode_in changes while the queue drains.
  always_comb begin
    enq   = 1'b0;
    xform = recv_data;
    rot_z = ZW'(recv_data);
    case (mode_q)
      MODE_W'(MODE_SUB): begin
        enq   = recv_new_data;
        xform = sub_char;
      end
      MODE_W'(MODE_ROT13): begin
        enq = recv_new_data;
        if ((rot_z >= ZW'(ROT_UC_LO_FIRST) && rot_z <= ZW'(ROT_UC_LO_LAST)) ||
            (rot_z >= ZW'(ROT_LC_LO_FIRST) && rot_z <= ZW'(ROT_LC_LO_LAST)))
          xform = recv_data + NUM_DATA_BITS'(ROT_SHIFT);
        else if ((rot_z >= ZW'(ROT_UC_HI_FIRST) && rot_z <= ZW'(ROT_UC_HI_LAST)) ||
                 (rot_z >= ZW'(ROT_LC_HI_FIRST) && rot_z <= ZW'(ROT_LC_HI_LAST)))
          xform = recv_data - NUM_DATA_BITS'(ROT_SHIFT);
      end
      MODE_W'(MODE_XOR): begin
        enq   = recv_new_data;
        xform = recv_data ^ xor_key;
      end
      MODE_W'(MODE_MATCH_REPL): begin
        enq   = recv_new_data;
        xform = (recv_data == match_char) ? replace_char : recv_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    full = (count_q == FIFO_FULL);
    idle = (state_q == ST_IDLE) && (count_q == '0);
    pop  = (state_q == ST_IDLE) && (count_q != '0) && send_ready;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    push = enq && (!full || pop);

    mode_d       = idle ? mode_in : mode_q;
    state_d      = state_q;
    send_start_d = 1'b0;
    send_data_d  = send_data_q;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          send_start_d = 1'b1;
          send_data_d  = mem_q[rd_ptr_q];
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (send_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);

    if (clear_status)          cnt_d = '0;
    else if (pop)              cnt_d = cnt_q + CNT_W'(1);
    else                       cnt_d = cnt_q;

    if (clear_status)          ovf_d = 1'b0;
    else if (enq && !push)     ovf_d = 1'b1;
    else                       ovf_d = ovf_q;

    select_d     = (mode_d != MODE_W'(MODE_FORWARD));
    keep_alive_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= xform;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_W'(MODE_FORWARD);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      select_q     <= 1'b0;
      send_start_q <= 1'b0;
      keep_alive_q <= 1'b0;
      send_data_q  <= '0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      select_q     <= select_d;
      send_start_q <= send_start_d;
      keep_alive_q <= keep_alive_d;
      send_data_q  <= send_data_d;
      ovf_q        <= ovf_d;
      cnt_q        <= cnt_d;
    end
  end

  assign select     = select_q;
  assign send_start = send_start_q;
  assign keep_alive = keep_alive_q;
  assign send_data  = send_data_q;
  assign ovf        = ovf_q;
  assign cnt        = cnt_q;

endmodule

// File: rtl/uart_mitm_engine.sv
// UART MITM engine: two independent direction channels between the bus
// interface receive outputs and its fake-send controls.
//   Direction 01: if0 receive -> fake_if1_* outputs, mode_01, ovf_01, cnt_01
//   Direction 10: if1 receive -> fake_if0_* outputs, mode_10, ovf_10, cnt_10
//   Operands and clear_status are shared by both directions.
module uart_mitm_engine
  import uart_mitm_pkg::*;
#(
  parameter int unsigned NUM_DATA_BITS = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned MODE_W        = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic [MODE_W-1:0]        mode_01,
  input  logic [MODE_W-1:0]        mode_10,
  input  logic [NUM_DATA_BITS-1:0] sub_char,
  input  logic [NUM_DATA_BITS-1:0] xor_key,
  input  logic [NUM_DATA_BITS-1:0] match_char,
  input  logic [NUM_DATA_BITS-1:0] replace_char,
  input  logic                     clear_status,
  input  logic                     if0_recv_new_data,
  input  logic                     if1_recv_new_data,
  input  logic [NUM_DATA_BITS-1:0] real_if0_recv_data,
  input  logic [NUM_DATA_BITS-1:0] real_if1_recv_data,
  input  logic                     fake_if0_send_ready,
  input  logic                     fake_if1_send_ready,
  input  logic                     fake_if0_send_done,
  input  logic                     fake_if1_send_done,
  output logic                     fake_if0_select,
  output logic                     fake_if1_select,
  output logic                     fake_if0_send_start,
  output logic                     fake_if1_send_start,
  output logic                     fake_if0_keep_alive,
  output logic                     fake_if1_keep_alive,
  output logic [NUM_DATA_BITS-1:0] fake_if0_send_data,
  output logic [NUM_DATA_BITS-1:0] fake_if1_send_data,
  output logic                     ovf_01,
  output logic                     ovf_10,
  output logic [CNT_W-1:0]         cnt_01,
  output logic [CNT_W-1:0]         cnt_10
);

  mitm_direction_channel #(
    .NUM_DATA_BITS(NUM_DATA_BITS),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .MODE_W       (MODE_W),
    .CNT_W        (CNT_W)
  ) u_ch01 (
    .clk          (sys_clk),
    .rst_n        (rst_n),
    .mode_in      (mode_01),
    .sub_char     (sub_char),
    .xor_key      (xor_key),
    .match_char   (match_char),
    .replace_char (replace_char),
    .clear_status (clear_status),
    .recv_new_data(if0_recv_new_data),
    .recv_data    (real_if0_recv_data),
    .send_ready   (fake_if1_send_ready),
    .send_done    (fake_if1_send_done),
    .select       (fake_if1_select),
    .send_start   (fake_if1_send_start),
    .keep_alive   (fake_if1_keep_alive),
    .send_data    (fake_if1_send_data),
    .ovf          (ovf_01),
    .cnt          (cnt_01)
  );

  mitm_direction_channel #(
    .NUM_DATA_BITS(NUM_DATA_BITS),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .MODE_W       (MODE_W),
    .CNT_W        (CNT_W)
  ) u_ch10 (
    .clk          (sys_clk),
    .rst_n        (rst_n),
    .mode_in      (mode_10),
    .sub_char     (sub_char),
    .xor_key      (xor_key),
    .match_char   (match_char),
    .replace_char (replace_char),
    .clear_status (clear_status),
    .recv_new_data(if1_recv_new_data),
    .recv_data    (real_if1_recv_data),
    .send_ready   (fake_if0_send_ready),
    .send_done    (fake_if0_send_done),
    .select       (fake_if0_select),
    .send_start   (fake_if0_send_start),
    .keep_alive   (fake_if0_keep_alive),
    .send_data    (fake_if0_send_data),
    .ovf          (ovf_10),
    .cnt          (cnt_10)
  );

endmodule

// File: doc/uart_mitm_engine.md
Name: uart_mitm_engine

Overview:
- Parametrised, per-direction UART MITM logic block; sits between the Bus interface module's receive status/data outputs and its fake-send controls.
- Each direction (if0->if1, if1->if0) has its own independently selected mode and its own byte FIFO, so bytes arriving while a fake send is in progress are queued rather than dropped.
- Adds XOR-key and match/replace modes, sticky overflow flags and injected-byte counters.

Parameters:
- NUM_DATA_BITS, 8, width of a UART data byte.
- FIFO_DEPTH, 4, entries per direction FIFO; power of two, at least 2.
- MODE_W, 3, width of each per-direction mode code.
- CNT_W, 16, width of the injected-byte counters.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode_01, mode_10  in  MODE_W each  mode code for if0->if1 and for if1->if0.
- sub_char, xor_key, match_char, replace_char  in  NUM_DATA_BITS each  mode operands, sampled at enqueue time.
- clear_status  in  1  synchronous clear of overflow flags and counters.
- if0_recv_new_data, if1_recv_new_data  in  1 each  one-cycle strobe: real byte received.
- real_if0_recv_data, real_if1_recv_data  in  NUM_DATA_BITS each  received byte.
- fake_if0_send_ready, fake_if1_send_ready, fake_if0_send_done, fake_if1_send_done  in  1 each  sender status.
- fake_if0_select, fake_if1_select  out  1 each  1 = fake line drives the interface.
- fake_if0_send_start, fake_if1_send_start  out  1 each  one-cycle send pulse.
- fake_if0_keep_alive, fake_if1_keep_alive  out  1 each  hold fake line between queued bytes.
- fake_if0_send_data, fake_if1_send_data  out  NUM_DATA_BITS each  byte to send.
- ovf_01, ovf_10  out  1 each  sticky FIFO overflow flags.
- cnt_01, cnt_10  out  CNT_W each  bytes injected per direction.

Behaviour:
Direction mapping:
- Direction 01 consumes the if0 receive signals and drives the fake_if1_* outputs.
- Direction 10 consumes the if1 receive signals and drives the fake_if0_* outputs.

Reset:
- While rst_n=0 (async assert, sync release), every output is 0.
- FIFOs are emptied, FSMs go to IDLE, and the active modes are set to FORWARD.

Modes:
- 0 FORWARD: no enqueue, select=0.
- 1 BLOCK: no enqueue, select=1.
- 2 SUB: enqueue sub_char.
- 3 ROT13: A-M/a-m get +13, N-Z/n-z get -13, all other values unchanged; comparisons on the zero-extended value.
- 4 XOR: enqueue data ^ xor_key.
- 5 MATCH_REPL: enqueue replace_char if data==match_char, else data.
- 6 and 7: treated as BLOCK.

Mode application:
- The mode input is registered into the active mode only when the direction is idle (FIFO empty and FSM in IDLE). Otherwise the change is deferred until idle.
- A byte is never half-processed under two modes.
- fake_ifX_select is registered from the active mode: 0 only for FORWARD.

Enqueue:
- recv_new_data at cycle t with a transforming mode writes the transformed byte into the FIFO at edge t+1.

Send FSM (per direction):
- IDLE: if FIFO non-empty and send_ready=1, load send_data from the FIFO head, pulse send_start, pop, increment cnt (wraps at 2^CNT_W), go to WAIT.
- WAIT: send_start=0; on send_done=1 go to IDLE.
- Minimum latency from recv strobe to send_start is 2 cycles.

keep_alive:
- Asserted while in WAIT with the FIFO non-empty, or in IDLE with the FIFO non-empty.
- Deasserted when FIFO empty and IDLE.

FIFO boundaries:
- Push to a full FIFO in the same cycle as a pop is accepted.
- Push to a full FIFO without a pop is dropped and sets ovf (sticky until clear_status or reset).
- Pop on empty never occurs.
- Read and write pointers wrap modulo FIFO_DEPTH; an extra pointer bit or count distinguishes full from empty.

clear_status:
- Takes priority over a same-cycle increment; counter becomes 0.

Reset mid-send:
- Aborts immediately; send_start drops asynchronously and queued bytes are lost.

Decomposition:
- Package uart_mitm_pkg holds the mode codes (MODE_FORWARD..MODE_MATCH_REPL), FSM state encodings, and the ROT13 range constants (65, 77, 78, 90, 97, 109, 110, 122).
- One sub-module, mitm_direction_channel: transform, FIFO, send FSM, counter and overflow for one direction.
- The top instantiates mitm_direction_channel twice and maps the ports crosswise.

Test Plan:
- mode_01=FORWARD, if0 strobe with 0x41 -> fake_if1_select=0, no send_start, cnt_01 stays 0.
- mode_01=ROT13, bytes 0x41, 0x6E, 0x31 -> fake_if1_send_data 0x4E, 0x61, 0x31 in order; first send_start 2 cycles after the strobe; cnt_01=3.
- mode_10=MATCH_REPL with match 0x0D, replace 0x0A; if1 bytes 0x0D, 0x0E -> fake_if0 sends 0x0A, 0x0E.
- FIFO_DEPTH=4, send_ready held 0, six strobes in direction 01 -> 4 queued, ovf_01=1, then 4 sends in order after ready rises; clear_status -> ovf_01=0, cnt_01=0.
- mode_01 changed from SUB(0x23) to XOR(0xFF) while 2 bytes are queued -> both queued bytes sent as 0x23; the next strobe with 0x0F sends 0xF0.
- rst_n pulled low during WAIT -> all outputs 0 immediately; after release, FIFO empty and mode FORWARD.
